// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-wide RAM controller / arbiter between instruction fetch (IF)
// and the MEM stage. Splits 32-bit fetches/loads and 1/2/4-byte stores into
// byte transfers on a single 8-bit RAM port and returns a one-cycle done pulse.
//
// Ports
//   clk, rst              clock, async active-low reset
//   if_req_i/if_addr_i    fetch request (held until if_done_o) and address
//   if_data_o, if_done_o  fetched word (little-endian), completion pulse
//   mem_r_enable_i        load request (held until mem_done_o)
//   mem_w_enable_i        store request (held until mem_done_o)
//   mem_addr_i            load/store address
//   mem_w_data_i          store data, byte i in bits [8i+7:8i]
//   mem_mask_i            store size: 01=1B, 10=2B, 11=4B, 00=none
//   mem_r_data_o          loaded word (little-endian)
//   mem_done_o            MEM completion pulse (ram_done)
//   mem_busy_o            controller serving IF (ram_busy)
//   ram_addr_o/ram_wr_o/ram_dout_o/ram_din_i  byte RAM port (read data
//                         arrives one cycle after its address)
//
// Build option
//   MEM_CTRL_FAIR_ARB_EN  alternate grants between IF and MEM when both are
//                         requesting; otherwise MEM always wins.
module mem_ctrl #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [31:0]       if_addr_i,
  output logic [31:0]       if_data_o,
  output logic              if_done_o,
  input  logic              mem_r_enable_i,
  input  logic              mem_w_enable_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       mem_w_data_i,
  input  logic [1:0]        mem_mask_i,
  output logic [31:0]       mem_r_data_o,
  output logic              mem_done_o,
  output logic              mem_busy_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_wr_o,
  output logic [7:0]        ram_dout_o,
  input  logic [7:0]        ram_din_i
);

  typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_t;

  state_t            state, state_nxt;
  logic [2:0]        cnt, cnt_nxt;
  logic [ADDR_W-1:0] base;
  logic [31:0]       wdata;
  logic [1:0]        mask;
  logic              srv_if;     // requester of the transaction in flight
  logic              mem_req, grant_if, grant_mem;
  logic [2:0]        last_idx;   // index of final store byte
  logic [1:0]        bidx;       // byte lane captured this cycle (cnt-1)

  // Upper address bits are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr_i[31:ADDR_W], mem_addr_i[31:ADDR_W]};

  assign mem_req = mem_r_enable_i | mem_w_enable_i;

`ifdef MEM_CTRL_FAIR_ARB_EN
  logic last_mem;  // previous grant went to MEM
  assign grant_if = if_req_i & (~mem_req | last_mem);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             last_mem <= 1'b0;
    else if (state == IDLE && grant_if)   last_mem <= 1'b0;
    else if (state == IDLE && grant_mem)  last_mem <= 1'b1;
  end
`else
  assign grant_if = if_req_i & ~mem_req;
`endif
  assign grant_mem = mem_req & ~grant_if;

  always_comb begin
    case (mask)
      2'b11:   last_idx = 3'd3;
      2'b10:   last_idx = 3'd1;
      default: last_idx = 3'd0;
    endcase
  end

  assign bidx = cnt[1:0] - 2'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    ram_addr_o = '0;
    ram_wr_o   = 1'b0;
    ram_dout_o = 8'h00;
    case (state)
      IDLE: begin
        if (grant_mem) begin
          if (mem_w_enable_i) state_nxt = (mem_mask_i == 2'b00) ? DONE : MEM_WR;
          else                state_nxt = MEM_RD;
        end else if (grant_if) begin
          state_nxt = IF_RD;
        end
      end
      IF_RD, MEM_RD: begin
        // cnt 0..3 issue addresses, cnt 1..4 collect the byte issued last cycle
        if (!cnt[2]) ram_addr_o = base + ADDR_W'(cnt);
        if (cnt == 3'd4) begin
          state_nxt = DONE;
          cnt_nxt   = 3'd0;
        end else begin
          cnt_nxt = cnt + 3'd1;
        end
      end
      MEM_WR: begin
        ram_wr_o   = 1'b1;
        ram_addr_o = base + ADDR_W'(cnt);
        ram_dout_o = wdata[8*cnt[1:0] +: 8];
        if (cnt == last_idx) begin
          state_nxt = DONE;
          cnt_nxt   = 3'd0;
        end else begin
          cnt_nxt = cnt + 3'd1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign if_done_o  = (state == DONE) &  srv_if;
  assign mem_done_o = (state == DONE) & ~srv_if;
  assign mem_busy_o = (state == IF_RD) | ((state == DONE) & srv_if);

  // Request capture in IDLE and read-byte assembly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base         <= '0;
      wdata        <= 32'h0;
      mask         <= 2'b00;
      srv_if       <= 1'b0;
      if_data_o    <= 32'h0;
      mem_r_data_o <= 32'h0;
    end else begin
      if (state == IDLE) begin
        srv_if <= grant_if;
        base   <= grant_mem ? mem_addr_i[ADDR_W-1:0] : if_addr_i[ADDR_W-1:0];
        wdata  <= mem_w_data_i;
        mask   <= mem_mask_i;
      end
      if (state == IF_RD  && cnt != 3'd0) if_data_o[8*bidx +: 8]    <= ram_din_i;
      if (state == MEM_RD && cnt != 3'd0) mem_r_data_o[8*bidx +: 8] <= ram_din_i;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: byte RAM model, shadow memory for expected
// data, and a scoreboard of expected completions popped on each done pulse.
module tb_mem_ctrl;

  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_i;
  logic [31:0]   if_addr_i;
  logic [31:0]   if_data_o;
  logic          if_done_o;
  logic          mem_r_enable_i, mem_w_enable_i;
  logic [31:0]   mem_addr_i, mem_w_data_i;
  logic [1:0]    mem_mask_i;
  logic [31:0]   mem_r_data_o;
  logic          mem_done_o, mem_busy_o;
  logic [AW-1:0] ram_addr_o;
  logic          ram_wr_o;
  logic [7:0]    ram_dout_o;
  logic [7:0]    ram_din_i;

  mem_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_data_o(if_data_o), .if_done_o(if_done_o),
    .mem_r_enable_i(mem_r_enable_i), .mem_w_enable_i(mem_w_enable_i),
    .mem_addr_i(mem_addr_i), .mem_w_data_i(mem_w_data_i),
    .mem_mask_i(mem_mask_i), .mem_r_data_o(mem_r_data_o),
    .mem_done_o(mem_done_o), .mem_busy_o(mem_busy_o),
    .ram_addr_o(ram_addr_o), .ram_wr_o(ram_wr_o),
    .ram_dout_o(ram_dout_o), .ram_din_i(ram_din_i)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [0:(1<<AW)-1];
  logic [7:0] sh  [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (ram_wr_o) ram[ram_addr_o] <= ram_dout_o;
    ram_din_i <= ram[ram_addr_o];
  end

  typedef struct {
    bit          is_if;
    bit          chk_data;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_if_data  = 32'h0;
  logic [31:0] exp_mem_data = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_word(input logic [AW-1:0] a);
    logic [AW-1:0] a1, a2, a3;
    a1 = a + 17'd1; a2 = a + 17'd2; a3 = a + 17'd3;
    return {sh[a3], sh[a2], sh[a1], sh[a]};
  endfunction

  // Called at a sampling point where a done pulse is visible.
  task automatic sb_pop(input string tag);
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL %s_sb_empty obs=done exp=none", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_if_done"},  if_done_o,  e.is_if);
      chk({tag, "_mem_done"}, mem_done_o, !e.is_if);
      if (e.chk_data) begin
        if (e.is_if) exp_if_data  = e.data;
        else         exp_mem_data = e.data;
      end
      chk({tag, "_if_data"},  if_data_o,    exp_if_data);
      chk({tag, "_mem_data"}, mem_r_data_o, exp_mem_data);
    end
  endtask

  task automatic drop_reqs();
    if_req_i = 0; mem_r_enable_i = 0; mem_w_enable_i = 0;
  endtask

  // One transaction, started at a negedge. Logs RAM port per cycle k after
  // acceptance and checks addresses, strobes, busy and completion latency.
  task automatic txn(input string tag, input bit is_if, input bit wr,
                     input logic [31:0] addr, input logic [31:0] data,
                     input logic [1:0] mask);
    int            n, lat, done_k, last_k;
    logic [AW-1:0] base, ea;
    logic [AW-1:0] a_log [0:11];
    logic          w_log [0:11];
    logic [7:0]    d_log [0:11];
    logic          b_log [0:11];
    exp_t          e;
    n    = (mask == 2'b11) ? 4 : int'(mask);
    lat  = (is_if || !wr) ? 6 : n + 1;
    base = addr[AW-1:0];
    e.is_if = is_if; e.chk_data = !wr; e.data = 32'h0;
    if (!wr) e.data = rd_word(base);
    else for (int i = 0; i < n; i++) begin
      ea = base + AW'(i);
      sh[ea] = data[8*i +: 8];
    end
    sb.push_back(e);
    if (is_if) begin if_req_i = 1; if_addr_i = addr; end
    else begin
      mem_addr_i = addr; mem_w_data_i = data; mem_mask_i = mask;
      if (wr) mem_w_enable_i = 1; else mem_r_enable_i = 1;
    end
    done_k = 0; last_k = 0;
    for (int k = 1; k <= 10 && done_k == 0; k++) begin
      @(posedge clk); @(negedge clk);
      a_log[k] = ram_addr_o; w_log[k] = ram_wr_o;
      d_log[k] = ram_dout_o; b_log[k] = mem_busy_o;
      last_k = k;
      if (if_done_o || mem_done_o) begin
        done_k = k;
        sb_pop(tag);
      end
    end
    drop_reqs();
    chk({tag, "_lat"}, done_k, lat);
    if (done_k == 0 && sb.size() != 0) void'(sb.pop_back());
    for (int k = 1; k <= lat && k <= last_k; k++) begin
      ea = base + AW'(k - 1);
      if (wr && k <= n) begin
        chk($sformatf("%s_wr%0d", tag, k),   w_log[k], 1);
        chk($sformatf("%s_addr%0d", tag, k), a_log[k], ea);
        chk($sformatf("%s_dout%0d", tag, k), d_log[k], data[8*(k-1) +: 8]);
      end else if (!wr && k <= 4) begin
        chk($sformatf("%s_wr%0d", tag, k),   w_log[k], 0);
        chk($sformatf("%s_addr%0d", tag, k), a_log[k], ea);
      end else begin
        chk($sformatf("%s_wr%0d", tag, k),   w_log[k], 0);
      end
      chk($sformatf("%s_busy%0d", tag, k), b_log[k], is_if);
    end
    if (done_k != 0) begin
      chk({tag, "_done_addr0"}, a_log[done_k], 0);
      chk({tag, "_done_dout0"}, d_log[done_k], 0);
    end
    @(posedge clk); @(negedge clk);
    chk({tag, "_pulse_end"}, {if_done_o, mem_done_o, ram_wr_o, mem_busy_o}, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"}, ram_addr_o, 0);
    chk({tag, "_wr"},   ram_wr_o, 0);
    chk({tag, "_dout"}, ram_dout_o, 0);
    chk({tag, "_ifd"},  if_data_o, 0);
    chk({tag, "_memd"}, mem_r_data_o, 0);
    chk({tag, "_done"}, {if_done_o, mem_done_o}, 0);
    chk({tag, "_busy"}, mem_busy_o, 0);
  endtask

  initial begin
    int ndone;
    exp_t e;
    rst = 0;
    if_req_i = 0; if_addr_i = 0;
    mem_r_enable_i = 0; mem_w_enable_i = 0;
    mem_addr_i = 0; mem_w_data_i = 0; mem_mask_i = 0;
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i] = 8'(i * 37 + 5);
      sh[i]  = 8'(i * 37 + 5);
    end
    ram[17'h100] = 8'h13; ram[17'h101] = 8'h05; ram[17'h102] = 8'h10; ram[17'h103] = 8'h00;
    sh[17'h100]  = 8'h13; sh[17'h101]  = 8'h05; sh[17'h102]  = 8'h10; sh[17'h103]  = 8'h00;

    @(negedge clk); @(negedge clk);
    chk_all_zero("reset");
    rst = 1;
    @(negedge clk);

    txn("fetch",  1, 0, 32'h0000_0100, 0, 2'b00);
    chk("fetch_word", if_data_o, 32'h0010_0513);
    txn("load_top",  0, 0, 32'h0001_FFFC, 0, 2'b00);
    txn("load_wrap", 0, 0, 32'hFFFF_FFFE, 0, 2'b00);
    txn("sh",     0, 1, 32'h0000_0200, 32'hBEEF_BEEF, 2'b10);
    txn("ld_sh",  0, 0, 32'h0000_0200, 0, 2'b00);
    txn("sb",     0, 1, 32'h0000_0205, 32'h1234_56A5, 2'b01);
    txn("mask00", 0, 1, 32'h0000_0210, 32'hFFFF_FFFF, 2'b00);
    txn("ld_sb",  0, 0, 32'h0000_0204, 0, 2'b00);
    txn("ld_m00", 0, 0, 32'h0000_0210, 0, 2'b00);
    txn("fetch2", 1, 0, 32'h0000_0104, 0, 2'b00);

    // Reset during the second byte of a word store.
    mem_w_enable_i = 1; mem_addr_i = 32'h300; mem_w_data_i = 32'h1122_3344; mem_mask_i = 2'b11;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("rst_pre_wr",   ram_wr_o, 1);
    chk("rst_pre_addr", ram_addr_o, 17'h301);
    rst = 0;
    #1;
    chk_all_zero("rst_mid");
    drop_reqs();
    sh[17'h300] = 8'h44;
    exp_if_data = 0; exp_mem_data = 0;
    @(posedge clk); @(negedge clk);
    rst = 1;
    @(negedge clk);
    txn("ld_rst",    0, 0, 32'h0000_0300, 0, 2'b00);
    txn("fetch_rst", 1, 0, 32'h0000_0100, 0, 2'b00);

    // Contention: IF and MEM load held together across three grants.
    e.chk_data = 1;
    e.is_if = 0; e.data = rd_word(17'h1FFFC); sb.push_back(e);
`ifdef MEM_CTRL_FAIR_ARB_EN
    e.is_if = 1; e.data = rd_word(17'h00108); sb.push_back(e);
`else
    e.is_if = 0; e.data = rd_word(17'h1FFFC); sb.push_back(e);
`endif
    e.is_if = 0; e.data = rd_word(17'h1FFFC); sb.push_back(e);
    if_req_i = 1; if_addr_i = 32'h108;
    mem_r_enable_i = 1; mem_addr_i = 32'h1FFFC;
    ndone = 0;
    for (int k = 0; k < 40 && ndone < 3; k++) begin
      @(posedge clk); @(negedge clk);
      if (if_done_o || mem_done_o) begin
        ndone++;
        sb_pop($sformatf("cont%0d", ndone));
      end
    end
    drop_reqs();
    chk("cont_count", ndone, 3);
    @(posedge clk); @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
